// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg
//   Shared encodings for the MIPS memory stage: access-size codes, the
//   memory-stage FSM state type, byte-enable constants and the store
//   byte-lane steering helpers used by pipeline_mem.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } mem_state_t;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_LO   = 4'b0011;
  localparam logic [3:0] BE_HI   = 4'b1100;
  localparam logic [3:0] BE_ALL  = 4'b1111;

  // Little-endian lane select for stores. Half accesses only look at
  // addr[1]; addr[0] is either trapped or ignored upstream.
  function automatic logic [3:0] store_be(input logic [1:0] size,
                                          input logic [1:0] addr);
    case (size)
      SZ_BYTE: store_be = BE_B0 << addr;
      SZ_HALF: store_be = addr[1] ? BE_HI : BE_LO;
      default: store_be = BE_ALL;
    endcase
  endfunction

  // Replicate the store data across all lanes; byte enables pick the lane.
  function automatic logic [31:0] store_wdata(input logic [1:0]  size,
                                              input logic [31:0] wd);
    case (size)
      SZ_BYTE: store_wdata = {4{wd[7:0]}};
      SZ_HALF: store_wdata = {2{wd[15:0]}};
      default: store_wdata = wd;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size,
                                      input logic [1:0] addr);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = addr[0];
      default: misaligned = (addr != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/pipeline_mem_loadext.sv
// pipeline_mem_loadext
//   Combinational load extraction: picks the byte/half/word out of the
//   returned memory word by the low address bits and sign- or zero-extends.
// Ports:
//   rdata      in  32  word returned by data memory
//   addr       in  2   effective address bits [1:0]
//   size       in  2   SZ_BYTE / SZ_HALF / SZ_WORD
//   unsigned_ld in 1   zero-extend when set
//   result     out 32  register-file ready value
module pipeline_mem_loadext
  import mips_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr)
      2'b00:   byte_sel = rdata[7:0];
      2'b01:   byte_sel = rdata[15:8];
      2'b10:   byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      SZ_BYTE: result = unsigned_ld ? {24'h0, byte_sel}
                                    : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: result = unsigned_ld ? {16'h0, half_sel}
                                    : {{16{half_sel[15]}}, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/pipeline_mem.sv
// pipeline_mem
//   MIPS memory stage plus MEM/WB pipeline register. Issues data-memory
//   accesses over a req/ack handshake, steers store lanes, extracts and
//   extends loads, and stalls the front of the pipeline while an access
//   is outstanding.
//
//   state  | meaning
//   IDLE   | no access in flight; non-memory ops pass straight to WB
//   ACCESS | dmem_req held with stable addr/be/wdata until dmem_ack
//   DONE   | stall released; WB loads latched controls and load data
//
// Ports:
//   clk, reset (async, active-low)
//   *_m          EX/MEM slot inputs; flush_m squashes the MEM instruction
//   stall_mem    freeze IF..EX/MEM registers
//   dmem_*       data-memory request/response
//   *_w          registered MEM/WB outputs
// Optional: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word
//   accesses (no bus request, adel_w/ades_w outputs).
module pipeline_mem
  import mips_mem_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_m,
  input  logic               memread_m,
  input  logic               memwrite_m,
  input  logic [1:0]         size_m,
  input  logic               unsigned_m,
  input  logic               memtoreg_m,
  input  logic               link_m,
  input  logic               regwrite_m,
  input  logic [REGBITS-1:0] writereg_m,
  input  logic [WIDTH-1:0]   aluout_m,
  input  logic [WIDTH-1:0]   writedata_m,
  input  logic [WIDTH-1:0]   pcplus4_m,
  input  logic               flush_m,
  output logic               stall_mem,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [WIDTH-1:0]   dmem_addr,
  output logic [3:0]         dmem_be,
  output logic [WIDTH-1:0]   dmem_wdata,
  input  logic [WIDTH-1:0]   dmem_rdata,
  input  logic               dmem_ack,
  output logic               memtoreg_w,
  output logic               link_w,
  output logic               regwrite_w,
  output logic [REGBITS-1:0] writereg_w,
  output logic [WIDTH-1:0]   aluout_w,
  output logic [WIDTH-1:0]   readdata_w,
  output logic [WIDTH-1:0]   pcplus4_w
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic               adel_w,
  output logic               ades_w
`endif
);

  mem_state_t         state_q, state_d;
  logic [WIDTH-1:0]   addr_q, addr_d;
  logic [3:0]         be_q, be_d;
  logic [WIDTH-1:0]   wdata_q, wdata_d;
  logic               we_q, we_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic               memtoreg_q, memtoreg_d;
  logic               link_q, link_d;
  logic               regwrite_q, regwrite_d;
  logic [REGBITS-1:0] writereg_q, writereg_d;
  logic [WIDTH-1:0]   pcplus4_q, pcplus4_d;
  logic               kill_q, kill_d;
  logic               mis_q, mis_d;
  logic [WIDTH-1:0]   hold_q, hold_d;

  logic               memtoreg_w_q, memtoreg_w_d;
  logic               link_w_q, link_w_d;
  logic               regwrite_w_q, regwrite_w_d;
  logic [REGBITS-1:0] writereg_w_q, writereg_w_d;
  logic [WIDTH-1:0]   aluout_w_q, aluout_w_d;
  logic [WIDTH-1:0]   readdata_w_q, readdata_w_d;
  logic [WIDTH-1:0]   pcplus4_w_q, pcplus4_w_d;

  logic               memop;
  logic               misalign;
  logic [WIDTH-1:0]   ext_data;

`ifdef MEM_MISALIGN_TRAP_EN
  logic rd_q, rd_d;
  logic adel_w_q, adel_w_d;
  logic ades_w_q, ades_w_d;
  assign misalign = misaligned(size_m, aluout_m[1:0]);
  assign adel_w   = adel_w_q;
  assign ades_w   = ades_w_q;
`else
  assign misalign = 1'b0;
`endif

  assign memop = valid_m & (memread_m | memwrite_m) & ~flush_m;

  pipeline_mem_loadext u_loadext (
    .rdata       (dmem_rdata),
    .addr        (addr_q[1:0]),
    .size        (size_q),
    .unsigned_ld (uns_q),
    .result      (ext_data)
  );

  // The IDLE term makes the stall visible in the same cycle the memop
  // arrives, so EX/MEM holds it while the request registers are loaded.
  assign stall_mem  = (state_q == ACCESS) | ((state_q == IDLE) & memop);
  assign dmem_req   = (state_q == ACCESS);
  assign dmem_we    = (state_q == ACCESS) & we_q;
  assign dmem_be    = (state_q == ACCESS) ? be_q : BE_NONE;
  assign dmem_addr  = {addr_q[WIDTH-1:2], 2'b00};
  assign dmem_wdata = wdata_q;

  assign memtoreg_w = memtoreg_w_q;
  assign link_w     = link_w_q;
  assign regwrite_w = regwrite_w_q;
  assign writereg_w = writereg_w_q;
  assign aluout_w   = aluout_w_q;
  assign readdata_w = readdata_w_q;
  assign pcplus4_w  = pcplus4_w_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    memtoreg_d   = memtoreg_q;
    link_d       = link_q;
    regwrite_d   = regwrite_q;
    writereg_d   = writereg_q;
    pcplus4_d    = pcplus4_q;
    kill_d       = kill_q;
    mis_d        = mis_q;
    hold_d       = hold_q;
    memtoreg_w_d = memtoreg_w_q;
    link_w_d     = link_w_q;
    // WB sees a bubble on every edge that does not retire an instruction.
    regwrite_w_d = 1'b0;
    writereg_w_d = writereg_w_q;
    aluout_w_d   = aluout_w_q;
    readdata_w_d = readdata_w_q;
    pcplus4_w_d  = pcplus4_w_q;
`ifdef MEM_MISALIGN_TRAP_EN
    rd_d         = rd_q;
    adel_w_d     = 1'b0;
    ades_w_d     = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (memop) begin
          addr_d     = aluout_m;
          be_d       = memwrite_m ? store_be(size_m, aluout_m[1:0]) : BE_ALL;
          wdata_d    = store_wdata(size_m, writedata_m);
          we_d       = memwrite_m;
          size_d     = size_m;
          uns_d      = unsigned_m;
          memtoreg_d = memtoreg_m;
          link_d     = link_m;
          regwrite_d = regwrite_m;
          writereg_d = writereg_m;
          pcplus4_d  = pcplus4_m;
          kill_d     = 1'b0;
          mis_d      = misalign;
`ifdef MEM_MISALIGN_TRAP_EN
          rd_d       = memread_m;
`endif
          state_d    = misalign ? DONE : ACCESS;
        end else begin
          memtoreg_w_d = memtoreg_m;
          link_w_d     = link_m;
          regwrite_w_d = regwrite_m & valid_m & ~flush_m;
          writereg_w_d = writereg_m;
          aluout_w_d   = aluout_m;
          readdata_w_d = '0;
          pcplus4_w_d  = pcplus4_m;
        end
      end

      ACCESS: begin
        // A flush cannot abort the bus cycle; it only suppresses writeback.
        kill_d = kill_q | flush_m;
        if (dmem_ack) begin
          hold_d  = ext_data;
          state_d = DONE;
        end
      end

      DONE: begin
        memtoreg_w_d = memtoreg_q;
        link_w_d     = link_q;
        regwrite_w_d = regwrite_q & ~kill_q & ~mis_q;
        writereg_w_d = writereg_q;
        aluout_w_d   = addr_q;
        readdata_w_d = hold_q;
        pcplus4_w_d  = pcplus4_q;
`ifdef MEM_MISALIGN_TRAP_EN
        adel_w_d     = mis_q & rd_q;
        ades_w_d     = mis_q & we_q;
`endif
        kill_d       = 1'b0;
        mis_d        = 1'b0;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      be_q         <= BE_NONE;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      size_q       <= SZ_BYTE;
      uns_q        <= 1'b0;
      memtoreg_q   <= 1'b0;
      link_q       <= 1'b0;
      regwrite_q   <= 1'b0;
      writereg_q   <= '0;
      pcplus4_q    <= '0;
      kill_q       <= 1'b0;
      mis_q        <= 1'b0;
      hold_q       <= '0;
      memtoreg_w_q <= 1'b0;
      link_w_q     <= 1'b0;
      regwrite_w_q <= 1'b0;
      writereg_w_q <= '0;
      aluout_w_q   <= '0;
      readdata_w_q <= '0;
      pcplus4_w_q  <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      rd_q         <= 1'b0;
      adel_w_q     <= 1'b0;
      ades_w_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      memtoreg_q   <= memtoreg_d;
      link_q       <= link_d;
      regwrite_q   <= regwrite_d;
      writereg_q   <= writereg_d;
      pcplus4_q    <= pcplus4_d;
      kill_q       <= kill_d;
      mis_q        <= mis_d;
      hold_q       <= hold_d;
      memtoreg_w_q <= memtoreg_w_d;
      link_w_q     <= link_w_d;
      regwrite_w_q <= regwrite_w_d;
      writereg_w_q <= writereg_w_d;
      aluout_w_q   <= aluout_w_d;
      readdata_w_q <= readdata_w_d;
      pcplus4_w_q  <= pcplus4_w_d;
`ifdef MEM_MISALIGN_TRAP_EN
      rd_q         <= rd_d;
      adel_w_q     <= adel_w_d;
      ades_w_q     <= ades_w_d;
`endif
    end
  end

endmodule

// File: tb/tb_pipeline_mem.sv
// tb_pipeline_mem
//   Scoreboard bench for pipeline_mem: a stimulus process issues one
//   instruction per MEM slot and pushes the expected MEM/WB result and the
//   expected bus request; a memory responder and a WB monitor pop and check.
`timescale 1ns/1ps
module tb_pipeline_mem;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        valid_m, memread_m, memwrite_m, unsigned_m;
  logic [1:0]  size_m;
  logic        memtoreg_m, link_m, regwrite_m, flush_m;
  logic [4:0]  writereg_m;
  logic [31:0] aluout_m, writedata_m, pcplus4_m;
  logic        stall_mem, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic        memtoreg_w, link_w, regwrite_w;
  logic [4:0]  writereg_w;
  logic [31:0] aluout_w, readdata_w, pcplus4_w;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        adel_w, ades_w;
`endif

  pipeline_mem #(.WIDTH(32), .REGBITS(5)) dut (
    .clk(clk), .reset(reset),
    .valid_m(valid_m), .memread_m(memread_m), .memwrite_m(memwrite_m),
    .size_m(size_m), .unsigned_m(unsigned_m), .memtoreg_m(memtoreg_m),
    .link_m(link_m), .regwrite_m(regwrite_m), .writereg_m(writereg_m),
    .aluout_m(aluout_m), .writedata_m(writedata_m), .pcplus4_m(pcplus4_m),
    .flush_m(flush_m), .stall_mem(stall_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack),
    .memtoreg_w(memtoreg_w), .link_w(link_w), .regwrite_w(regwrite_w),
    .writereg_w(writereg_w), .aluout_w(aluout_w), .readdata_w(readdata_w),
    .pcplus4_w(pcplus4_w)
`ifdef MEM_MISALIGN_TRAP_EN
    , .adel_w(adel_w), .ades_w(ades_w)
`endif
  );

  typedef struct {
    logic        valid, rd, wr, flush, uns, memtoreg, link, regwrite;
    logic [1:0]  size;
    logic [4:0]  writereg;
    logic [31:0] aluout, wd, pcplus4;
    int          waits;
    int          kill_idx;
  } instr_t;

  typedef struct {
    logic        memtoreg, link, regwrite, chk_rd, adel, ades;
    logic [4:0]  writereg;
    logic [31:0] aluout, pcplus4, readdata;
  } wexp_t;

  typedef struct {
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        we;
    int          waits;
  } rexp_t;

  wexp_t       wq[$];
  rexp_t       rq[$];
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  int          checks = 0;
  int          errors = 0;
  logic        mon_en = 1'b0;
  logic        resp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] a,
                                           input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    case (sz)
      2'd0: begin
        v = (word >> (8 * a)) & 32'hFF;
        if (!uns && v[7]) v = v | 32'hFFFF_FF00;
      end
      2'd1: begin
        v = (word >> (16 * a[1])) & 32'hFFFF;
        if (!uns && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [1:0] a,
                                            input logic [1:0] sz, input logic [31:0] wd);
    int sh;
    case (sz)
      2'd0: begin sh = 8 * a;     return (old & ~(32'hFF << sh))   | ((wd & 32'hFF) << sh);   end
      2'd1: begin sh = 16 * a[1]; return (old & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh); end
      default: return wd;
    endcase
  endfunction

  function automatic instr_t blank();
    instr_t in;
    in.valid = 1'b0; in.rd = 1'b0; in.wr = 1'b0; in.flush = 1'b0; in.uns = 1'b0;
    in.memtoreg = 1'b0; in.link = 1'b0; in.regwrite = 1'b0; in.size = 2'd2;
    in.writereg = 5'd0; in.aluout = 32'h0; in.wd = 32'h0; in.pcplus4 = 32'h0;
    in.waits = 0; in.kill_idx = -1;
    return in;
  endfunction

  task automatic drive(input instr_t in);
    valid_m = in.valid; memread_m = in.rd; memwrite_m = in.wr; size_m = in.size;
    unsigned_m = in.uns; memtoreg_m = in.memtoreg; link_m = in.link;
    regwrite_m = in.regwrite; writereg_m = in.writereg; aluout_m = in.aluout;
    writedata_m = in.wd; pcplus4_m = in.pcplus4; flush_m = in.flush;
  endtask

  task automatic issue(input instr_t in);
    logic  memop, mis, killed;
    wexp_t e;
    rexp_t r;
    int    stalls, acc, exp_stall, kidx, idx;
    logic [31:0] a;
    @(negedge clk);
    drive(in);
    mon_en = 1'b1;
    a      = in.aluout;
    idx    = int'(a[9:2]);
    memop  = in.valid && (in.rd || in.wr) && !in.flush;
    mis    = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    mis = memop && ((in.size == 2'd1 && a[0]) || (in.size == 2'd2 && a[1:0] != 2'b00));
`endif
    kidx   = mis ? -1 : in.kill_idx;
    killed = memop && !mis && kidx >= 0 && kidx <= in.waits;

    e.memtoreg = in.memtoreg; e.link = in.link; e.writereg = in.writereg;
    e.aluout = in.aluout; e.pcplus4 = in.pcplus4;
    e.regwrite = memop ? (in.regwrite && !killed && !mis) : (in.regwrite && in.valid && !in.flush);
    e.chk_rd   = memop && in.rd && !mis;
    e.readdata = ref_load(ref_mem[idx], a[1:0], in.size, in.uns);
    e.adel     = mis && in.rd;
    e.ades     = mis && in.wr;

    if (memop && !mis) begin
      r.addr = {a[31:2], 2'b00}; r.we = in.wr; r.waits = in.waits;
      r.be = 4'hF; r.wdata = 32'h0;
      if (in.wr) begin
        case (in.size)
          2'd0:    begin r.be = 4'b0001 << a[1:0];           r.wdata = {4{in.wd[7:0]}};  end
          2'd1:    begin r.be = a[1] ? 4'b1100 : 4'b0011;    r.wdata = {2{in.wd[15:0]}}; end
          default: begin r.be = 4'b1111;                     r.wdata = in.wd;            end
        endcase
        ref_mem[idx] = ref_store(ref_mem[idx], a[1:0], in.size, in.wd);
      end
      rq.push_back(r);
    end
    wq.push_back(e);

    exp_stall = mis ? 1 : (memop ? 2 + in.waits : 0);
    stalls = 0;
    acc    = 0;
    #1;
    while (stall_mem === 1'b1 && stalls < 40) begin
      stalls++;
      @(negedge clk);
      flush_m = (acc == kidx);
      acc++;
      #1;
    end
    chk("stall_cycles", stalls, exp_stall);
  endtask

  // Memory responder: checks each request against the scoreboard, holds it
  // for the chosen number of wait cycles, then acks with the stored word.
  initial begin : responder
    rexp_t cur;
    bit    busy, unexp;
    int    cnt, wi;
    busy = 0; unexp = 0; cnt = 0;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      dmem_ack = 1'b0;
      if (!resp_en) continue;
      if (dmem_req === 1'b1) begin
        if (!busy) begin
          busy = 1;
          if (rq.size() == 0) begin
            checks++; errors++; unexp = 1; cnt = 0;
            $display("FAIL req_unexpected: request at 0x%08h with none expected", dmem_addr);
          end else begin
            unexp = 0; cur = rq.pop_front(); cnt = cur.waits;
          end
        end
        if (!unexp) begin
          chk("req_addr", dmem_addr, cur.addr);
          chk("req_be", {28'h0, dmem_be}, {28'h0, cur.be});
          chk("req_we", {31'h0, dmem_we}, {31'h0, cur.we});
          if (cur.we) chk("req_wdata", dmem_wdata, cur.wdata);
        end
        if (cnt == 0) begin
          wi = int'(dmem_addr[9:2]);
          dmem_ack   = 1'b1;
          dmem_rdata = mem[wi];
          if (dmem_we) begin
            for (int b = 0; b < 4; b++)
              if (dmem_be[b]) mem[wi][8*b +: 8] = dmem_wdata[8*b +: 8];
          end
          busy = 0;
        end else begin
          cnt--;
          dmem_rdata = $urandom;
        end
      end else begin
        busy = 0;
        if ($urandom_range(0, 7) == 0) begin
          dmem_ack   = 1'b1;
          dmem_rdata = $urandom;
        end
      end
    end
  end

  // WB monitor: an edge retires an instruction whenever stall_mem was low.
  initial begin : monitor
    logic  s, en;
    wexp_t e;
    forever begin
      @(negedge clk);
      #2;
      s  = stall_mem;
      en = mon_en;
      @(posedge clk);
      #1;
      if (en && !s) begin
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL w_unexpected: WB retire with empty scoreboard, aluout_w 0x%08h", aluout_w);
        end else begin
          e = wq.pop_front();
          chk("w_memtoreg", {31'h0, memtoreg_w}, {31'h0, e.memtoreg});
          chk("w_link", {31'h0, link_w}, {31'h0, e.link});
          chk("w_regwrite", {31'h0, regwrite_w}, {31'h0, e.regwrite});
          chk("w_writereg", {27'h0, writereg_w}, {27'h0, e.writereg});
          chk("w_aluout", aluout_w, e.aluout);
          chk("w_pcplus4", pcplus4_w, e.pcplus4);
          if (e.chk_rd) chk("w_readdata", readdata_w, e.readdata);
`ifdef MEM_MISALIGN_TRAP_EN
          chk("w_adel", {31'h0, adel_w}, {31'h0, e.adel});
          chk("w_ades", {31'h0, ades_w}, {31'h0, e.ades});
`endif
        end
      end
`ifdef MEM_MISALIGN_TRAP_EN
      else if (en) begin
        chk("w_adel_idle", {31'h0, adel_w}, 32'h0);
        chk("w_ades_idle", {31'h0, ades_w}, 32'h0);
      end
`endif
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk_w_zero(input string tag);
    chk({tag, "_memtoreg_w"}, {31'h0, memtoreg_w}, 32'h0);
    chk({tag, "_link_w"}, {31'h0, link_w}, 32'h0);
    chk({tag, "_regwrite_w"}, {31'h0, regwrite_w}, 32'h0);
    chk({tag, "_writereg_w"}, {27'h0, writereg_w}, 32'h0);
    chk({tag, "_aluout_w"}, aluout_w, 32'h0);
    chk({tag, "_readdata_w"}, readdata_w, 32'h0);
    chk({tag, "_pcplus4_w"}, pcplus4_w, 32'h0);
  endtask

  initial begin : stimulus
    instr_t in;
    int     k;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[8'h40] = 32'h80FF_0000;
    ref_mem[8'h40] = 32'h80FF_0000;

    // Reset state, then reset in the middle of an access.
    reset = 1'b0;
    drive(blank());
    repeat (2) @(negedge clk);
    chk("rst_dmem_req", {31'h0, dmem_req}, 32'h0);
    chk("rst_dmem_we", {31'h0, dmem_we}, 32'h0);
    chk("rst_dmem_be", {28'h0, dmem_be}, 32'h0);
    chk("rst_dmem_addr", dmem_addr, 32'h0);
    chk("rst_dmem_wdata", dmem_wdata, 32'h0);
    chk_w_zero("rst");
    reset = 1'b1;
    @(negedge clk);
    in = blank(); in.valid = 1'b1; in.rd = 1'b1; in.regwrite = 1'b1; in.aluout = 32'h104;
    drive(in);
    #1 chk("rst_idle_stall", {31'h0, stall_mem}, 32'h1);
    @(negedge clk);
    #1 chk("rst_pre_req", {31'h0, dmem_req}, 32'h1);
    #2;
    drive(blank());
    reset = 1'b0;
    #1;
    chk("rst_mid_req", {31'h0, dmem_req}, 32'h0);
    chk("rst_mid_be", {28'h0, dmem_be}, 32'h0);
    chk_w_zero("rst_mid");
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_after_req", {31'h0, dmem_req}, 32'h0);
      chk("rst_after_regwrite_w", {31'h0, regwrite_w}, 32'h0);
    end

    resp_en = 1'b1;

    // Directed cases.
    in = blank(); in.valid = 1'b1; in.regwrite = 1'b1; in.aluout = 32'h1234;
    in.writereg = 5'd7; in.pcplus4 = 32'h400;
    issue(in);
    in = blank(); in.valid = 1'b1; in.rd = 1'b1; in.size = 2'd0; in.memtoreg = 1'b1;
    in.regwrite = 1'b1; in.writereg = 5'd8; in.aluout = 32'h103; in.waits = 2; in.pcplus4 = 32'h404;
    issue(in);
    in.uns = 1'b1; in.writereg = 5'd9; in.pcplus4 = 32'h408;
    issue(in);
    in = blank(); in.valid = 1'b1; in.wr = 1'b1; in.size = 2'd1; in.aluout = 32'h202;
    in.wd = 32'h0000_ABCD; in.pcplus4 = 32'h40C;
    issue(in);
    in = blank(); in.valid = 1'b1; in.rd = 1'b1; in.size = 2'd2; in.regwrite = 1'b1;
    in.memtoreg = 1'b1; in.writereg = 5'd10; in.aluout = 32'h100; in.waits = 1; in.kill_idx = 0;
    in.pcplus4 = 32'h410;
    issue(in);
    in = blank(); in.valid = 1'b1; in.rd = 1'b1; in.size = 2'd1; in.regwrite = 1'b1;
    in.memtoreg = 1'b1; in.writereg = 5'd11; in.aluout = 32'h202; in.pcplus4 = 32'h414;
    issue(in);
`ifdef MEM_MISALIGN_TRAP_EN
    in = blank(); in.valid = 1'b1; in.rd = 1'b1; in.size = 2'd2; in.regwrite = 1'b1;
    in.writereg = 5'd12; in.aluout = 32'h101; in.pcplus4 = 32'h418;
    issue(in);
`endif

    // Randomised instruction stream.
    for (int n = 0; n < 300; n++) begin
      in = blank();
      in.valid    = ($urandom_range(0, 9) != 0);
      k           = $urandom_range(0, 9);
      in.rd       = (k >= 4 && k < 7);
      in.wr       = (k >= 7);
      in.size     = 2'($urandom_range(0, 2));
      in.uns      = 1'($urandom_range(0, 1));
      in.memtoreg = 1'($urandom_range(0, 1));
      in.link     = 1'($urandom_range(0, 1));
      in.regwrite = in.wr ? 1'b0 : 1'($urandom_range(0, 1));
      in.writereg = 5'($urandom_range(0, 31));
      in.aluout   = (in.rd || in.wr) ? 32'($urandom_range(0, 1023)) : $urandom;
      in.wd       = $urandom;
      in.pcplus4  = $urandom;
      in.flush    = ($urandom_range(0, 9) == 0);
      in.waits    = $urandom_range(0, 3);
      in.kill_idx = ($urandom_range(0, 4) == 0) ? $urandom_range(0, in.waits) : -1;
      issue(in);
    end

    @(negedge clk);
    mon_en = 1'b0;
    drive(blank());
    repeat (3) @(negedge clk);
    chk("wq_drained", wq.size(), 32'h0);
    chk("rq_drained", rq.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
